// File: rtl/sparce_sasa_table.sv
// SparCE SASA table: memory-mapped programmable skip descriptors,
// looked up against the fetch PC every cycle with a one-cycle registered result.
module sparce_sasa_table #(
    parameter int unsigned SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_BASE    = 32'hFFFF_F000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    input  logic        sasa_wen,
    input  logic        sasa_enable,
    output logic [31:0] preceding_pc,
    output logic [4:0]  sasa_rs1,
    output logic [4:0]  sasa_rs2,
    output logic        condition,
    output logic [15:0] insts_to_skip,
    output logic        valid
);

    localparam int unsigned IDX_W    = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;
    localparam logic [31:0] CTRL_OFF = 32'(8 * SASA_ENTRIES);
    localparam logic [31:0] LIMIT    = 32'(8 * SASA_ENTRIES + 4);
    localparam logic        SASA_COND_OR = 1'b0;

    // Table storage
    logic [SASA_ENTRIES-1:0] r_vld;
    logic [31:0]             r_epc  [SASA_ENTRIES];
    logic [4:0]              r_rs1  [SASA_ENTRIES];
    logic [4:0]              r_rs2  [SASA_ENTRIES];
    logic                    r_cond [SASA_ENTRIES];
    logic [15:0]             r_skip [SASA_ENTRIES];

    // Registered lookup result
    logic        r_valid;
    logic [31:0] r_ppc;
    logic [4:0]  r_rs1_o;
    logic [4:0]  r_rs2_o;
    logic        r_cond_o;
    logic [15:0] r_skip_o;

    // Write decode
    logic [31:0]      w_off;
    logic             w_acc;
    logic             w_ctrl;
    logic             w_entry_wr;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_data;

    // Lookup result
    logic        w_hit;
    logic [31:0] w_hit_epc;
    logic [4:0]  w_hit_rs1;
    logic [4:0]  w_hit_rs2;
    logic        w_hit_cond;
    logic [15:0] w_hit_skip;

    assign w_off         = sasa_addr - SASA_BASE;
    assign w_acc         = sasa_wen && (sasa_addr[1:0] == 2'b00) && (w_off < LIMIT);
    assign w_ctrl        = w_acc && (w_off == CTRL_OFF);
    assign w_entry_wr    = w_acc && !w_ctrl;
    assign w_idx         = IDX_W'(w_off >> 3);
    assign w_unused_data = ^sasa_data[15:11];

    // Valid bits: reset and control-word clear win; word 0 invalidates, word 1 validates
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_vld <= '0;
        end else if (w_ctrl) begin
            if (sasa_data[0]) begin
                r_vld <= '0;
            end
        end else if (w_entry_wr) begin
            r_vld[w_idx] <= w_off[2];
        end
    end

    // Entry payloads; no reset needed, a write during reset is dropped
    always_ff @(posedge CLK) begin
        if (nRST && w_entry_wr) begin
            if (!w_off[2]) begin
                r_epc[w_idx] <= sasa_data;
            end else begin
                r_rs1[w_idx]  <= sasa_data[4:0];
                r_rs2[w_idx]  <= sasa_data[9:5];
                r_cond[w_idx] <= sasa_data[10];
                r_skip[w_idx] <= sasa_data[31:16];
            end
        end
    end

    // Priority match: scan high to low so the lowest matching index wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_epc  = '0;
        w_hit_rs1  = '0;
        w_hit_rs2  = '0;
        w_hit_cond = SASA_COND_OR;
        w_hit_skip = '0;
        for (int i = int'(SASA_ENTRIES) - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_epc[i] == pc) && (r_skip[i] != 16'd0)) begin
                w_hit      = 1'b1;
                w_hit_epc  = r_epc[i];
                w_hit_rs1  = r_rs1[i];
                w_hit_rs2  = r_rs2[i];
                w_hit_cond = r_cond[i];
                w_hit_skip = r_skip[i];
            end
        end
    end

    // Output register: descriptors load on an enabled hit and hold otherwise
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid  <= 1'b0;
            r_ppc    <= '0;
            r_rs1_o  <= '0;
            r_rs2_o  <= '0;
            r_cond_o <= SASA_COND_OR;
            r_skip_o <= '0;
        end else begin
            r_valid <= w_hit && sasa_enable;
            if (w_hit && sasa_enable) begin
                r_ppc    <= w_hit_epc;
                r_rs1_o  <= w_hit_rs1;
                r_rs2_o  <= w_hit_rs2;
                r_cond_o <= w_hit_cond;
                r_skip_o <= w_hit_skip;
            end
        end
    end

    assign valid         = r_valid;
    assign preceding_pc  = r_ppc;
    assign sasa_rs1      = r_rs1_o;
    assign sasa_rs2      = r_rs2_o;
    assign condition     = r_cond_o;
    assign insts_to_skip = r_skip_o;

endmodule
